touch_report_reader: RTL and testbench

- Producer side of the touch-report interface consumed by the MTL gesture/zoom control logic.
- Waits for the panel's active-low touch interrupt, then requests a 10-byte burst register read from the I2C read engine.
- Parses the returned bytes into the X1/Y1/X2/Y2, touch-count and gesture registers, and presents them with a level oREADY whose rising edge marks a new, stable report.

---
 rtl/touch_report_reader.sv | 219 +++++++++++++++++++++
 tb/tb_touch_report_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_report_reader.sv
// Touch-report producer: on panel interrupt, burst-reads 10 report bytes
// through the I2C read engine and publishes them behind a level oREADY.
module touch_report_reader #(
    parameter logic [7:0] START_ADDR     = 8'h10,
    parameter int         MIN_HIGH       = 4,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iTOUCH_INT_N,
    output logic       oRD_REQ,
    output logic [7:0] oRD_ADDR,
    output logic [3:0] oRD_LEN,
    input  logic       iRD_ACK,
    input  logic       iBYTE_VALID,
    input  logic [7:0] iBYTE,
    input  logic       iRD_DONE,
    input  logic       iRD_ERR,
    output logic       oREADY,
    output logic [9:0] oREG_X1,
    output logic [8:0] oREG_Y1,
    output logic [9:0] oREG_X2,
    output logic [8:0] oREG_Y2,
    output logic [1:0] oREG_TOUCH_COUNT,
    output logic [7:0] oREG_GESTURE,
    output logic       oERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(MIN_HIGH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RECV, S_COMMIT, S_HOLD, S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic          pend_q, pend_d;
    logic          rd_req_q, rd_req_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    sh_gest_q, sh_gest_d;
    logic [3:0]    sh_cnt_q, sh_cnt_d;
    logic [9:0]    sh_x1_q, sh_x1_d, sh_x2_q, sh_x2_d;
    logic [8:0]    sh_y1_q, sh_y1_d, sh_y2_q, sh_y2_d;
    logic [7:0]    gest_q, gest_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [9:0]    x1_q, x1_d, x2_q, x2_d;
    logic [8:0]    y1_q, y1_d, y2_q, y2_d;
    logic          int_fall;

    function automatic logic [9:0] clamp_x(input logic [9:0] v);
        return (v > 10'd799) ? 10'd799 : v;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] v);
        return (v > 9'd479) ? 9'd479 : v;
    endfunction

    assign int_fall = s3_q & ~s2_q;

    always_comb begin
        state_d   = state_q;
        s1_d      = iTOUCH_INT_N;
        s2_d      = s1_q;
        s3_d      = s2_q;
        pend_d    = pend_q | int_fall;
        rd_req_d  = rd_req_q;
        ready_d   = ready_q;
        err_d     = 1'b0;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        hold_d    = hold_q;
        sh_gest_d = sh_gest_q;
        sh_cnt_d  = sh_cnt_q;
        sh_x1_d   = sh_x1_q;
        sh_y1_d   = sh_y1_q;
        sh_x2_d   = sh_x2_q;
        sh_y2_d   = sh_y2_q;
        gest_d    = gest_q;
        cnt_d     = cnt_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x2_d      = x2_q;
        y2_d      = y2_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    // a fresh edge in this very cycle stays pending
                    pend_d   = int_fall;
                    rd_req_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (iRD_ACK) begin
                    rd_req_d = 1'b0;
                    idx_d    = 4'd0;
                    tmo_d    = '0;
                    state_d  = S_RECV;
                end
            end
            S_RECV: begin
                tmo_d = tmo_q + 1'b1;
                if (iBYTE_VALID && idx_q < 4'd10) begin
                    idx_d = idx_q + 4'd1;
                    case (idx_q)
                        4'd0: sh_gest_d = iBYTE;
                        4'd1: sh_cnt_d = iBYTE[3:0];
                        4'd2: sh_x1_d[9:8] = iBYTE[1:0];
                        4'd3: sh_x1_d[7:0] = iBYTE;
                        4'd4: sh_y1_d[8] = iBYTE[0];
                        4'd5: sh_y1_d[7:0] = iBYTE;
                        4'd6: sh_x2_d[9:8] = iBYTE[1:0];
                        4'd7: sh_x2_d[7:0] = iBYTE;
                        4'd8: sh_y2_d[8] = iBYTE[0];
                        default: sh_y2_d[7:0] = iBYTE;
                    endcase
                end
                if (iRD_ERR || tmo_q == TW'(TIMEOUT_CYCLES - 1) ||
                    (iRD_DONE && (idx_d != 4'd10 || sh_cnt_d > 4'd2))) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else if (iRD_DONE) begin
                    // outputs land now, oREADY follows a cycle later
                    gest_d  = sh_gest_d;
                    cnt_d   = sh_cnt_d[1:0];
                    x1_d    = clamp_x(sh_x1_d);
                    y1_d    = clamp_y(sh_y1_d);
                    x2_d    = clamp_x(sh_x2_d);
                    y2_d    = clamp_y(sh_y2_d);
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                ready_d = 1'b1;
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(MIN_HIGH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s3_q      <= 1'b1;
            pend_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            tmo_q     <= '0;
            hold_q    <= '0;
            sh_gest_q <= '0;
            sh_cnt_q  <= '0;
            sh_x1_q   <= '0;
            sh_y1_q   <= '0;
            sh_x2_q   <= '0;
            sh_y2_q   <= '0;
            gest_q    <= '0;
            cnt_q     <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pend_q    <= pend_d;
            rd_req_q  <= rd_req_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            sh_gest_q <= sh_gest_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_x1_q   <= sh_x1_d;
            sh_y1_q   <= sh_y1_d;
            sh_x2_q   <= sh_x2_d;
            sh_y2_q   <= sh_y2_d;
            gest_q    <= gest_d;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
        end
    end

    assign oRD_REQ          = rd_req_q;
    assign oRD_ADDR         = START_ADDR;
    assign oRD_LEN          = 4'd10;
    assign oREADY           = ready_q;
    assign oERR             = err_q;
    assign oREG_GESTURE     = gest_q;
    assign oREG_TOUCH_COUNT = cnt_q;
    assign oREG_X1          = x1_q;
    assign oREG_Y1          = y1_q;
    assign oREG_X2          = x2_q;
    assign oREG_Y2          = y2_q;

endmodule

// File: tb/tb_touch_report_reader.sv
// Directed bench for touch_report_reader: burst parsing, clamping,
// abort paths, interrupt collapsing and asynchronous reset.
module tb_touch_report_reader;

    logic       iCLK;
    logic       iRST;
    logic       iTOUCH_INT_N;
    logic       oRD_REQ;
    logic [7:0] oRD_ADDR;
    logic [3:0] oRD_LEN;
    logic       iRD_ACK;
    logic       iBYTE_VALID;
    logic [7:0] iBYTE;
    logic       iRD_DONE;
    logic       iRD_ERR;
    logic       oREADY;
    logic [9:0] oREG_X1;
    logic [8:0] oREG_Y1;
    logic [9:0] oREG_X2;
    logic [8:0] oREG_Y2;
    logic [1:0] oREG_TOUCH_COUNT;
    logic [7:0] oREG_GESTURE;
    logic       oERR;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] bq [0:15];

    touch_report_reader dut (
        .iCLK(iCLK), .iRST(iRST), .iTOUCH_INT_N(iTOUCH_INT_N),
        .oRD_REQ(oRD_REQ), .oRD_ADDR(oRD_ADDR), .oRD_LEN(oRD_LEN),
        .iRD_ACK(iRD_ACK), .iBYTE_VALID(iBYTE_VALID), .iBYTE(iBYTE),
        .iRD_DONE(iRD_DONE), .iRD_ERR(iRD_ERR), .oREADY(oREADY),
        .oREG_X1(oREG_X1), .oREG_Y1(oREG_Y1), .oREG_X2(oREG_X2),
        .oREG_Y2(oREG_Y2), .oREG_TOUCH_COUNT(oREG_TOUCH_COUNT),
        .oREG_GESTURE(oREG_GESTURE), .oERR(oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // interrupt, ack after 3 cycles, stream nb bytes, then DONE or ERR
    task automatic do_read(input string tag, input int nb, input bit use_err,
                           input bit extra_int);
        int n;
        iTOUCH_INT_N = 1'b0;
        repeat (3) tick();
        iTOUCH_INT_N = 1'b1;
        n = 0;
        while (!oRD_REQ && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, 32'(oRD_REQ), 1);
        check({tag, "_ready_drop"}, 32'(oREADY), 0);
        repeat (3) tick();
        iRD_ACK = 1'b1;
        tick();
        iRD_ACK = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (extra_int) begin
                if (i == 2 || i == 6) iTOUCH_INT_N = 1'b0;
                if (i == 4 || i == 8) iTOUCH_INT_N = 1'b1;
            end
            iBYTE_VALID = 1'b1;
            iBYTE = bq[i];
            tick();
        end
        iBYTE_VALID = 1'b0;
        iTOUCH_INT_N = 1'b1;
        if (use_err) iRD_ERR = 1'b1;
        else iRD_DONE = 1'b1;
        tick();
        iRD_DONE = 1'b0;
        iRD_ERR = 1'b0;
    endtask

    initial begin
        int h;
        int rises;
        logic prev;
        bit req_seen;
        iRST = 1'b1;
        iTOUCH_INT_N = 1'b1;
        iRD_ACK = 1'b0;
        iBYTE_VALID = 1'b0;
        iBYTE = 8'h00;
        iRD_DONE = 1'b0;
        iRD_ERR = 1'b0;
        repeat (2) tick();
        iRST = 1'b0;

        // idle: nothing may happen without an interrupt
        req_seen = 1'b0;
        repeat (1000) begin
            tick();
            if (oRD_REQ) req_seen = 1'b1;
        end
        check("idle_no_req", 32'(req_seen), 0);
        check("idle_ready", 32'(oREADY), 0);
        check("idle_x1", 32'(oREG_X1), 0);
        check("idle_gest", 32'(oREG_GESTURE), 0);
        check("idle_err", 32'(oERR), 0);
        check("rd_addr", 32'(oRD_ADDR), 32'h10);
        check("rd_len", 32'(oRD_LEN), 10);

        // basic single-touch report
        bq = '{8'h1C, 8'h01, 8'h02, 8'h10, 8'h01, 8'h2C, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_read("r1", 10, 1'b0, 1'b0);
        check("r1_ready_at_update", 32'(oREADY), 0);
        check("r1_gest", 32'(oREG_GESTURE), 32'h1C);
        check("r1_x1", 32'(oREG_X1), 528);
        check("r1_y1", 32'(oREG_Y1), 300);
        check("r1_cnt", 32'(oREG_TOUCH_COUNT), 1);
        check("r1_x2", 32'(oREG_X2), 0);
        tick();
        check("r1_ready_rise", 32'(oREADY), 1);
        h = 0;
        repeat (6) begin
            tick();
            if (oREADY) h++;
        end
        check("r1_ready_hold", 32'(h), 6);

        // clamping of both points
        bq = '{8'h05, 8'h02, 8'h03, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00,
               8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_read("r2", 10, 1'b0, 1'b0);
        check("r2_x1_clamp", 32'(oREG_X1), 799);
        check("r2_y1_clamp", 32'(oREG_Y1), 479);
        check("r2_x2", 32'(oREG_X2), 256);
        check("r2_y2", 32'(oREG_Y2), 100);
        check("r2_cnt", 32'(oREG_TOUCH_COUNT), 2);
        check("r2_gest", 32'(oREG_GESTURE), 32'h05);
        repeat (8) tick();

        // bus error after four bytes
        bq = '{8'hAA, 8'h01, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_read("e1", 4, 1'b1, 1'b0);
        check("e1_err", 32'(oERR), 1);
        check("e1_ready", 32'(oREADY), 0);
        check("e1_x1_kept", 32'(oREG_X1), 799);
        check("e1_gest_kept", 32'(oREG_GESTURE), 32'h05);
        h = 0;
        repeat (5) begin
            tick();
            if (oERR) h++;
            if (oRD_REQ) h += 100;
        end
        check("e1_single_pulse_idle", 32'(h), 0);

        // short burst
        do_read("e2", 9, 1'b0, 1'b0);
        check("e2_err", 32'(oERR), 1);
        check("e2_y1_kept", 32'(oREG_Y1), 479);
        repeat (3) tick();

        // illegal touch count
        bq[1] = 8'h03;
        do_read("e3", 10, 1'b0, 1'b0);
        check("e3_err", 32'(oERR), 1);
        check("e3_ready", 32'(oREADY), 0);
        check("e3_cnt_kept", 32'(oREG_TOUCH_COUNT), 2);
        repeat (3) tick();

        // over-long burst: bytes 10 and 11 ignored
        bq = '{8'h22, 8'h02, 8'h01, 8'h00, 8'h00, 8'h50, 8'h00, 8'h64,
               8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        do_read("r3", 12, 1'b0, 1'b0);
        check("r3_err", 32'(oERR), 0);
        check("r3_gest", 32'(oREG_GESTURE), 32'h22);
        check("r3_x1", 32'(oREG_X1), 256);
        check("r3_y1", 32'(oREG_Y1), 80);
        check("r3_x2", 32'(oREG_X2), 100);
        check("r3_y2", 32'(oREG_Y2), 256);
        tick();
        check("r3_ready_rise", 32'(oREADY), 1);
        repeat (8) tick();

        // two extra edges during RECV collapse to one follow-up request
        bq = '{8'h33, 8'h01, 8'h00, 8'h40, 8'h00, 8'h20, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_read("r4", 10, 1'b0, 1'b1);
        check("r4_x1", 32'(oREG_X1), 64);
        rises = 0;
        prev = oRD_REQ;
        repeat (30) begin
            tick();
            if (oRD_REQ && !prev) rises++;
            prev = oRD_REQ;
        end
        check("r4_one_more_req", 32'(rises), 1);

        // reset in RECV discards everything
        iRD_ACK = 1'b1;
        tick();
        iRD_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iBYTE_VALID = 1'b1;
            iBYTE = bq[i];
            tick();
        end
        iBYTE_VALID = 1'b0;
        iRST = 1'b1;
        #1;
        check("rst_req", 32'(oRD_REQ), 0);
        check("rst_ready", 32'(oREADY), 0);
        check("rst_x1", 32'(oREG_X1), 0);
        check("rst_gest", 32'(oREG_GESTURE), 0);
        tick();
        iRST = 1'b0;
        for (int i = 3; i < 10; i++) begin
            iBYTE_VALID = 1'b1;
            iBYTE = bq[i];
            tick();
        end
        iBYTE_VALID = 1'b0;
        iRD_DONE = 1'b1;
        tick();
        iRD_DONE = 1'b0;
        h = 0;
        repeat (5) begin
            tick();
            if (oREADY || oRD_REQ) h++;
        end
        check("rst_no_commit", 32'(h), 0);
        check("rst_x1_after", 32'(oREG_X1), 0);

        // reset in REQ drops the request at once
        iTOUCH_INT_N = 1'b0;
        repeat (3) tick();
        iTOUCH_INT_N = 1'b1;
        h = 0;
        while (!oRD_REQ && h < 20) begin
            tick();
            h++;
        end
        check("req2_seen", 32'(oRD_REQ), 1);
        iRST = 1'b1;
        #1;
        check("rst_req_drop", 32'(oRD_REQ), 0);
        tick();
        iRST = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
